inst_buffer: RTL and testbench

INST_BUFFER -- requirements
Module: inst_buffer

---
 rtl/inst_buffer_if.sv | 41 ++++
 rtl/inst_buffer.sv | 117 +++++++++++
 tb/tb_inst_buffer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/inst_buffer_if.sv
// Shared packet type and the fetch/decode-side bundle of the instruction buffer.
//   inst_buffer_pkg : IF_ID_PACKET struct and the NOP encoding for empty slots.
//   inst_buffer_if  : flush, rollback and the three fetch ways, inputs to the buffer.
//                     Also the three decode ways, if_ready and count, outputs of the buffer.
//   modport master  : fetch/decode/control side (drives fetch ways, flush, rollback).
//   modport slave   : the buffer itself.
package inst_buffer_pkg;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
  } IF_ID_PACKET;
endpackage

interface inst_buffer_if #(parameter int DEPTH = 8);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                        flush;
  logic [1:0]                  rollback;
  inst_buffer_pkg::IF_ID_PACKET if_packet_0;
  inst_buffer_pkg::IF_ID_PACKET if_packet_1;
  inst_buffer_pkg::IF_ID_PACKET if_packet_2;
  inst_buffer_pkg::IF_ID_PACKET id_packet_0;
  inst_buffer_pkg::IF_ID_PACKET id_packet_1;
  inst_buffer_pkg::IF_ID_PACKET id_packet_2;
  logic                        if_ready;
  logic [CW-1:0]               count;

  modport master (
    output flush, rollback, if_packet_0, if_packet_1, if_packet_2,
    input  id_packet_0, id_packet_1, id_packet_2, if_ready, count
  );

  modport slave (
    input  flush, rollback, if_packet_0, if_packet_1, if_packet_2,
    output id_packet_0, id_packet_1, id_packet_2, if_ready, count
  );
endinterface

// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and decode: a DEPTH-entry circular queue.
// It accepts up to three fetched ways per cycle and presents the oldest three
// entries to decode. Decode may withhold its youngest ways through rollback.
//   clock : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : inst_buffer_if.slave (fetch ways, flush, rollback in; decode ways,
//           if_ready, count out)
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input logic           clock,
  input logic           reset,
  inst_buffer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  IF_ID_PACKET    r_mem [DEPTH];
  logic [PW-1:0]  r_head;
  logic [PW-1:0]  r_tail;
  logic [CW-1:0]  r_count;

  IF_ID_PACKET    w_in  [3];
  IF_ID_PACKET    w_out [3];
  logic [PW-1:0]  w_rd_idx [3];
  logic           w_wr_en  [3];
  logic [PW-1:0]  w_wr_idx [3];
  logic           w_ready;
  logic [1:0]     w_n_out;
  logic [1:0]     w_avail;
  logic [1:0]     w_deq;
  logic [1:0]     w_enq;

  assign w_in[0] = bus.if_packet_0;
  assign w_in[1] = bus.if_packet_1;
  assign w_in[2] = bus.if_packet_2;

  // Readiness from registered occupancy only; pointer wrap is free since DEPTH is a power of two.
  always_comb begin
    w_ready = (r_count <= CW'(DEPTH - 3));
    for (int k = 0; k < 3; k++) begin
      w_rd_idx[k] = r_head + PW'(k);
      if (CW'(k) < r_count) begin
        w_out[k]       = r_mem[w_rd_idx[k]];
        w_out[k].valid = 1'b1;
      end else begin
        w_out[k] = '{valid: 1'b0, inst: NOP, PC: 32'd0, NPC: 32'd0};
      end
    end
  end

  // Dequeue count: visible ways minus those withheld from the youngest end.
  always_comb begin
    if (r_count >= CW'(3)) begin
      w_n_out = 2'd3;
    end else begin
      w_n_out = r_count[1:0];
    end
    w_avail = 2'd3 - bus.rollback;
    if (w_n_out < w_avail) begin
      w_deq = w_n_out;
    end else begin
      w_deq = w_avail;
    end
  end

  // Compact valid fetch ways onto consecutive tail slots, skipping invalid ways.
  always_comb begin
    logic [1:0] v_off;
    v_off = 2'd0;
    for (int k = 0; k < 3; k++) begin
      w_wr_en[k]  = 1'b0;
      w_wr_idx[k] = r_tail + PW'(v_off);
      if (w_in[k].valid && w_ready && !bus.flush) begin
        w_wr_en[k] = 1'b1;
        v_off      = v_off + 2'd1;
      end else begin
        w_wr_en[k] = 1'b0;
      end
    end
    w_enq = v_off;
  end

  // Pointer and occupancy state; reset beats flush, flush discards this cycle's enqueue.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_deq);
      r_tail  <= r_tail + PW'(w_enq);
      r_count <= r_count + CW'(w_enq) - CW'(w_deq);
    end
  end

  // Entry storage has no reset; validity comes only from r_count.
  always_ff @(posedge clock) begin
    for (int k = 0; k < 3; k++) begin
      if (!reset && w_wr_en[k]) begin
        r_mem[w_wr_idx[k]] <= w_in[k];
      end
    end
  end

  assign bus.id_packet_0 = w_out[0];
  assign bus.id_packet_1 = w_out[1];
  assign bus.id_packet_2 = w_out[2];
  assign bus.if_ready    = w_ready;
  assign bus.count       = r_count;
endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer: directed scenarios followed by random
// traffic, compared against a queue-based reference model.
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  localparam int DEPTH = 8;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  inst_buffer_if #(.DEPTH(DEPTH)) bus ();

  inst_buffer #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  IF_ID_PACKET model_q[$];
  IF_ID_PACKET inv_pkt;
  int unsigned next_pc  = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic IF_ID_PACKET mk(input logic v, input logic [31:0] pc);
    IF_ID_PACKET p;
    p.valid = v;
    p.inst  = {pc[15:0], ~pc[15:0]};
    p.PC    = pc;
    p.NPC   = pc + 32'd4;
    return p;
  endfunction

  // Apply one cycle of inputs, check outputs against the model, then advance.
  task automatic step(input logic rst, input logic fl, input logic [1:0] rb,
                      input IF_ID_PACKET p0, input IF_ID_PACKET p1, input IF_ID_PACKET p2);
    IF_ID_PACKET obs  [3];
    IF_ID_PACKET ways [3];
    IF_ID_PACKET exp_p;
    int          deq;
    bit          rdy;
    reset           = rst;
    bus.flush       = fl;
    bus.rollback    = rb;
    bus.if_packet_0 = p0;
    bus.if_packet_1 = p1;
    bus.if_packet_2 = p2;
    #1;
    obs[0] = bus.id_packet_0;
    obs[1] = bus.id_packet_1;
    obs[2] = bus.id_packet_2;
    for (int k = 0; k < 3; k++) begin
      exp_p = (k < model_q.size()) ? model_q[k] : inv_pkt;
      check_eq($sformatf("slot%0d", k), obs[k], exp_p);
    end
    check_eq("count", 128'(bus.count), 128'(model_q.size()));
    check_eq("if_ready", 128'(bus.if_ready), 128'(model_q.size() <= DEPTH - 3));
    // reference model update
    ways[0] = p0;
    ways[1] = p1;
    ways[2] = p2;
    rdy = (model_q.size() <= DEPTH - 3);
    deq = (model_q.size() < 3) ? model_q.size() : 3;
    if (deq > 3 - int'(rb)) deq = 3 - int'(rb);
    if (rst || fl) begin
      model_q.delete();
    end else begin
      repeat (deq) void'(model_q.pop_front());
      if (rdy) begin
        for (int k = 0; k < 3; k++) begin
          if (ways[k].valid) model_q.push_back(ways[k]);
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic [1:0] rb);
    step(1'b0, 1'b0, rb, inv_pkt, inv_pkt, inv_pkt);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 2'd0, inv_pkt, inv_pkt, inv_pkt);
  endtask

  initial begin
    inv_pkt         = '{valid: 1'b0, inst: NOP, PC: 32'd0, NPC: 32'd0};
    reset           = 1'b1;
    bus.flush       = 1'b0;
    bus.rollback    = 2'd0;
    bus.if_packet_0 = inv_pkt;
    bus.if_packet_1 = inv_pkt;
    bus.if_packet_2 = inv_pkt;
    @(posedge clock);
    #1;
    do_reset();

    // three packets in, out next cycle, empty after
    step(1'b0, 1'b0, 2'd0, mk(1'b1, 32'd0), mk(1'b1, 32'd4), mk(1'b1, 32'd8));
    check_eq("r030_pc0", 128'(bus.id_packet_0.PC), 128'd0);
    check_eq("r030_pc1", 128'(bus.id_packet_1.PC), 128'd4);
    check_eq("r030_pc2", 128'(bus.id_packet_2.PC), 128'd8);
    idle(2'd0);
    check_eq("r030_cnt", 128'(bus.count), 128'd0);
    check_eq("r030_v0", 128'(bus.id_packet_0.valid), 128'd0);

    // rollback=1 with four buffered entries
    do_reset();
    step(1'b0, 1'b0, 2'd3, mk(1'b1, 32'd0), mk(1'b1, 32'd4), mk(1'b1, 32'd8));
    step(1'b0, 1'b0, 2'd3, mk(1'b1, 32'd12), inv_pkt, inv_pkt);
    idle(2'd1);
    check_eq("r031_pc0", 128'(bus.id_packet_0.PC), 128'd8);
    check_eq("r031_pc1", 128'(bus.id_packet_1.PC), 128'd12);
    check_eq("r031_v2", 128'(bus.id_packet_2.valid), 128'd0);
    check_eq("r031_cnt", 128'(bus.count), 128'd2);

    // not ready at count=6: fetch ignored
    do_reset();
    step(1'b0, 1'b0, 2'd3, mk(1'b1, 32'd0), mk(1'b1, 32'd4), mk(1'b1, 32'd8));
    step(1'b0, 1'b0, 2'd3, mk(1'b1, 32'd12), mk(1'b1, 32'd16), mk(1'b1, 32'd20));
    step(1'b0, 1'b0, 2'd3, mk(1'b1, 32'd24), mk(1'b1, 32'd28), mk(1'b1, 32'd32));
    check_eq("r032_cnt", 128'(bus.count), 128'd6);
    check_eq("r032_rdy", 128'(bus.if_ready), 128'd0);
    check_eq("r032_pc0", 128'(bus.id_packet_0.PC), 128'd0);
    step(1'b0, 1'b0, 2'd1, mk(1'b1, 32'd24), mk(1'b1, 32'd28), mk(1'b1, 32'd32));
    check_eq("r032_cnt2", 128'(bus.count), 128'd4);

    // sparse fetch ways compact
    do_reset();
    step(1'b0, 1'b0, 2'd3, mk(1'b1, 32'd100), mk(1'b0, 32'd104), mk(1'b1, 32'd108));
    check_eq("r033_pc0", 128'(bus.id_packet_0.PC), 128'd100);
    check_eq("r033_pc1", 128'(bus.id_packet_1.PC), 128'd108);
    check_eq("r033_v2", 128'(bus.id_packet_2.valid), 128'd0);

    // flush with same-cycle fetch; reset with flush while half full
    do_reset();
    step(1'b0, 1'b0, 2'd3, mk(1'b1, 32'd0), mk(1'b1, 32'd4), mk(1'b1, 32'd8));
    step(1'b0, 1'b1, 2'd0, mk(1'b1, 32'd12), mk(1'b1, 32'd16), mk(1'b1, 32'd20));
    check_eq("r035_cnt", 128'(bus.count), 128'd0);
    check_eq("r035_rdy", 128'(bus.if_ready), 128'd1);
    check_eq("r035_v0", 128'(bus.id_packet_0.valid), 128'd0);
    step(1'b0, 1'b0, 2'd3, mk(1'b1, 32'd0), mk(1'b1, 32'd4), mk(1'b1, 32'd8));
    step(1'b0, 1'b0, 2'd3, mk(1'b1, 32'd12), inv_pkt, inv_pkt);
    check_eq("r035_half", 128'(bus.count), 128'd4);
    step(1'b1, 1'b1, 2'd0, mk(1'b1, 32'd16), mk(1'b1, 32'd20), mk(1'b1, 32'd24));
    check_eq("r035_cnt2", 128'(bus.count), 128'd0);
    check_eq("r035_rdy2", 128'(bus.if_ready), 128'd1);

    // random traffic across many pointer wraps
    next_pc = 32'd1000;
    for (int c = 0; c < 400; c++) begin
      IF_ID_PACKET w [3];
      logic        f;
      logic        r;
      for (int k = 0; k < 3; k++) begin
        logic v;
        v    = 1'($urandom_range(0, 1));
        w[k] = mk(v, next_pc);
        if (v) next_pc = next_pc + 4;
      end
      f = ($urandom_range(0, 39) == 0);
      r = ($urandom_range(0, 99) == 0);
      step(r, f, 2'($urandom_range(0, 3)), w[0], w[1], w[2]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
